// File: rtl/battle_front_scan.sv
// Sequential front-line scanner: walks every friendly/enemy slot once, tracks the
// most advanced live unit on each side, then applies the margin and engagement test.
module battle_front_scan #(
   parameter int NUM_SLOTS   = 16,
   parameter int LOC_W       = 9,
   parameter int TYPE_W      = 2,
   parameter int MARGIN      = 10,
   parameter int ENGAGE_DIST = 20,
   localparam int IDX_W      = $clog2(NUM_SLOTS)
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        Start,
   input  logic                        Ack,
   input  logic [NUM_SLOTS*LOC_W-1:0]  unitLoc,
   input  logic [NUM_SLOTS*TYPE_W-1:0] unitType,
   input  logic [NUM_SLOTS*LOC_W-1:0]  enemyLoc,
   input  logic [NUM_SLOTS*TYPE_W-1:0] enemyType,
   output logic [LOC_W-1:0]            friendlyFront,
   output logic [LOC_W-1:0]            enemyFront,
   output logic [IDX_W:0]              unitDamageSelect,
   output logic [IDX_W:0]              enemyDamageSelect,
   output logic [IDX_W:0]              unitCount,
   output logic [IDX_W:0]              enemyCount,
   output logic                        engaged,
   output logic                        Done
);

   localparam int                EXT_W      = LOC_W + 2;
   localparam logic [LOC_W-1:0]  FIELD_MAX  = {LOC_W{1'b1}};
   localparam logic [IDX_W:0]    TOWER      = {1'b1, {IDX_W{1'b0}}};
   localparam logic [IDX_W:0]    SCAN_END   = (IDX_W+1)'(NUM_SLOTS);
   localparam logic [LOC_W-1:0]  MARGIN_L   = LOC_W'(MARGIN);
   localparam logic [EXT_W-1:0]  MARGIN_X   = EXT_W'(MARGIN);
   localparam logic [EXT_W-1:0]  ENGAGE_X   = EXT_W'(ENGAGE_DIST);
   localparam logic [EXT_W-1:0]  FIELD_X    = EXT_W'(FIELD_MAX);

   typedef enum logic [1:0] {IDLE, SCAN, ADJUST, DONE} state_t;

   logic [LOC_W-1:0] unit_loc  [NUM_SLOTS];
   logic [LOC_W-1:0] enemy_loc [NUM_SLOTS];
   logic [NUM_SLOTS-1:0] unit_live, enemy_live;

   generate
      for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
         assign unit_loc[gi]   = unitLoc[gi*LOC_W +: LOC_W];
         assign enemy_loc[gi]  = enemyLoc[gi*LOC_W +: LOC_W];
         assign unit_live[gi]  = |unitType[gi*TYPE_W +: TYPE_W];
         assign enemy_live[gi] = |enemyType[gi*TYPE_W +: TYPE_W];
      end
   endgenerate

   state_t            state_q, state_d;
   logic [IDX_W:0]    idx_q, idx_d;
   logic [LOC_W-1:0]  raw_friendly_q, raw_friendly_d, raw_enemy_q, raw_enemy_d;
   logic [IDX_W:0]    acc_unit_sel_q, acc_unit_sel_d, acc_enemy_sel_q, acc_enemy_sel_d;
   logic [IDX_W:0]    acc_unit_cnt_q, acc_unit_cnt_d, acc_enemy_cnt_q, acc_enemy_cnt_d;
   logic [LOC_W-1:0]  friendly_front_q, friendly_front_d, enemy_front_q, enemy_front_d;
   logic [IDX_W:0]    unit_sel_q, unit_sel_d, enemy_sel_q, enemy_sel_d;
   logic [IDX_W:0]    unit_cnt_q, unit_cnt_d, enemy_cnt_q, enemy_cnt_d;
   logic              engaged_q, engaged_d, done_q, done_d;

   logic [IDX_W-1:0]  slot_idx;
   logic [EXT_W-1:0]  f_ext, e_ext, gap;

   always_comb begin
      state_d          = state_q;
      idx_d            = idx_q;
      raw_friendly_d   = raw_friendly_q;
      raw_enemy_d      = raw_enemy_q;
      acc_unit_sel_d   = acc_unit_sel_q;
      acc_enemy_sel_d  = acc_enemy_sel_q;
      acc_unit_cnt_d   = acc_unit_cnt_q;
      acc_enemy_cnt_d  = acc_enemy_cnt_q;
      friendly_front_d = friendly_front_q;
      enemy_front_d    = enemy_front_q;
      unit_sel_d       = unit_sel_q;
      enemy_sel_d      = enemy_sel_q;
      unit_cnt_d       = unit_cnt_q;
      enemy_cnt_d      = enemy_cnt_q;
      engaged_d        = engaged_q;
      done_d           = done_q;
      slot_idx         = idx_q[IDX_W-1:0];
      f_ext            = {2'b00, raw_friendly_q};
      e_ext            = {2'b00, raw_enemy_q};
      gap              = f_ext - e_ext;

      case (state_q)
         IDLE: begin
            if (Start) begin
               state_d          = SCAN;
               idx_d            = '0;
               raw_friendly_d   = FIELD_MAX;
               raw_enemy_d      = '0;
               acc_unit_sel_d   = TOWER;
               acc_enemy_sel_d  = TOWER;
               acc_unit_cnt_d   = '0;
               acc_enemy_cnt_d  = '0;
               friendly_front_d = FIELD_MAX;
               enemy_front_d    = '0;
               unit_sel_d       = TOWER;
               enemy_sel_d      = TOWER;
               unit_cnt_d       = '0;
               enemy_cnt_d      = '0;
               engaged_d        = 1'b0;
            end
         end
         SCAN: begin
            // The index runs one past the last slot so the hand-off costs a cycle.
            if (idx_q == SCAN_END) begin
               state_d = ADJUST;
            end else begin
               idx_d = idx_q + 1'b1;
               if (unit_live[slot_idx]) begin
                  acc_unit_cnt_d = acc_unit_cnt_q + 1'b1;
                  if (unit_loc[slot_idx] < raw_friendly_q) begin
                     raw_friendly_d = unit_loc[slot_idx];
                     acc_unit_sel_d = {1'b0, slot_idx};
                  end
               end
               if (enemy_live[slot_idx]) begin
                  acc_enemy_cnt_d = acc_enemy_cnt_q + 1'b1;
                  if (enemy_loc[slot_idx] > raw_enemy_q) begin
                     raw_enemy_d     = enemy_loc[slot_idx];
                     acc_enemy_sel_d = {1'b0, slot_idx};
                  end
               end
            end
         end
         ADJUST: begin
            state_d          = DONE;
            done_d           = 1'b1;
            friendly_front_d = (f_ext < MARGIN_X) ? '0 : raw_friendly_q - MARGIN_L;
            enemy_front_d    = ((e_ext + MARGIN_X) > FIELD_X) ? FIELD_MAX : raw_enemy_q + MARGIN_L;
            unit_sel_d       = acc_unit_sel_q;
            enemy_sel_d      = acc_enemy_sel_q;
            unit_cnt_d       = acc_unit_cnt_q;
            enemy_cnt_d      = acc_enemy_cnt_q;
            engaged_d        = (acc_unit_cnt_q != '0) && (acc_enemy_cnt_q != '0) &&
                               ((raw_friendly_q <= raw_enemy_q) || (gap <= ENGAGE_X));
         end
         DONE: begin
            if (Ack) begin
               state_d = IDLE;
               done_d  = 1'b0;
            end
         end
         default: begin
            state_d = IDLE;
            done_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q          <= IDLE;
         idx_q            <= '0;
         raw_friendly_q   <= FIELD_MAX;
         raw_enemy_q      <= '0;
         acc_unit_sel_q   <= TOWER;
         acc_enemy_sel_q  <= TOWER;
         acc_unit_cnt_q   <= '0;
         acc_enemy_cnt_q  <= '0;
         friendly_front_q <= FIELD_MAX;
         enemy_front_q    <= '0;
         unit_sel_q       <= TOWER;
         enemy_sel_q      <= TOWER;
         unit_cnt_q       <= '0;
         enemy_cnt_q      <= '0;
         engaged_q        <= 1'b0;
         done_q           <= 1'b0;
      end else begin
         state_q          <= state_d;
         idx_q            <= idx_d;
         raw_friendly_q   <= raw_friendly_d;
         raw_enemy_q      <= raw_enemy_d;
         acc_unit_sel_q   <= acc_unit_sel_d;
         acc_enemy_sel_q  <= acc_enemy_sel_d;
         acc_unit_cnt_q   <= acc_unit_cnt_d;
         acc_enemy_cnt_q  <= acc_enemy_cnt_d;
         friendly_front_q <= friendly_front_d;
         enemy_front_q    <= enemy_front_d;
         unit_sel_q       <= unit_sel_d;
         enemy_sel_q      <= enemy_sel_d;
         unit_cnt_q       <= unit_cnt_d;
         enemy_cnt_q      <= enemy_cnt_d;
         engaged_q        <= engaged_d;
         done_q           <= done_d;
      end
   end

   assign friendlyFront     = friendly_front_q;
   assign enemyFront        = enemy_front_q;
   assign unitDamageSelect  = unit_sel_q;
   assign enemyDamageSelect = enemy_sel_q;
   assign unitCount         = unit_cnt_q;
   assign enemyCount        = enemy_cnt_q;
   assign engaged           = engaged_q;
   assign Done              = done_q;

endmodule

// File: tb/tb_battle_front_scan.sv
// Scoreboard bench for battle_front_scan: expected results are queued at Start
// and compared when Done rises; a second small instance covers odd sizing.
module tb_battle_front_scan;

   localparam int NS = 16;
   localparam int LW = 9;
   localparam int TW = 2;
   localparam int IW = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic Start = 1'b0;
   logic Ack = 1'b0;
   logic [NS*LW-1:0] unitLoc, enemyLoc;
   logic [NS*TW-1:0] unitType, enemyType;
   logic [LW-1:0]    friendlyFront, enemyFront;
   logic [IW:0]      unitDamageSelect, enemyDamageSelect, unitCount, enemyCount;
   logic             engaged, Done;

   logic [LW-1:0] u_loc [NS];
   logic [LW-1:0] e_loc [NS];
   logic [TW-1:0] u_typ [NS];
   logic [TW-1:0] e_typ [NS];

   generate
      for (genvar gi = 0; gi < NS; gi++) begin : g_pack
         assign unitLoc[gi*LW +: LW]   = u_loc[gi];
         assign enemyLoc[gi*LW +: LW]  = e_loc[gi];
         assign unitType[gi*TW +: TW]  = u_typ[gi];
         assign enemyType[gi*TW +: TW] = e_typ[gi];
      end
   endgenerate

   always #5 clk = ~clk;

   battle_front_scan dut (
      .clk(clk), .rst(rst), .Start(Start), .Ack(Ack),
      .unitLoc(unitLoc), .unitType(unitType), .enemyLoc(enemyLoc), .enemyType(enemyType),
      .friendlyFront(friendlyFront), .enemyFront(enemyFront),
      .unitDamageSelect(unitDamageSelect), .enemyDamageSelect(enemyDamageSelect),
      .unitCount(unitCount), .enemyCount(enemyCount), .engaged(engaged), .Done(Done)
   );

   // Five-slot, ten-bit instance with every slot empty.
   logic        start5 = 1'b0;
   logic        ack5 = 1'b0;
   logic [49:0] loc5 = '0;
   logic [9:0]  typ5 = '0;
   logic [9:0]  ff5, ef5;
   logic [3:0]  us5, es5, uc5, ec5;
   logic        eng5, done5;

   battle_front_scan #(.NUM_SLOTS(5), .LOC_W(10)) dut5 (
      .clk(clk), .rst(rst), .Start(start5), .Ack(ack5),
      .unitLoc(loc5), .unitType(typ5), .enemyLoc(loc5), .enemyType(typ5),
      .friendlyFront(ff5), .enemyFront(ef5),
      .unitDamageSelect(us5), .enemyDamageSelect(es5),
      .unitCount(uc5), .enemyCount(ec5), .engaged(eng5), .Done(done5)
   );

   typedef struct packed {
      logic [LW-1:0] ff;
      logic [LW-1:0] ef;
      logic [IW:0]   us;
      logic [IW:0]   es;
      logic [IW:0]   uc;
      logic [IW:0]   ec;
      logic          eng;
   } exp_t;

   exp_t sb_q[$];
   int n_checks = 0;
   int n_pass = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   task automatic push_exp(input int ff, input int ef, input int us, input int es,
                           input int uc, input int ec, input int eng);
      exp_t e;
      e.ff  = ff[LW-1:0];
      e.ef  = ef[LW-1:0];
      e.us  = us[IW:0];
      e.es  = es[IW:0];
      e.uc  = uc[IW:0];
      e.ec  = ec[IW:0];
      e.eng = eng[0];
      sb_q.push_back(e);
   endtask

   // Reference: nearest live unit to the enemy tower, farthest live enemy, first index wins ties.
   task automatic model_push();
      int rf = 511, re = 0, us = 16, es = 16, uc = 0, ec = 0, ff, ef, eng;
      for (int i = 0; i < NS; i++) begin
         if (u_typ[i] != 0) begin
            uc++;
            if (int'(u_loc[i]) < rf) begin rf = int'(u_loc[i]); us = i; end
         end
         if (e_typ[i] != 0) begin
            ec++;
            if (int'(e_loc[i]) > re) begin re = int'(e_loc[i]); es = i; end
         end
      end
      ff  = (rf < 10) ? 0 : rf - 10;
      ef  = (re + 10 > 511) ? 511 : re + 10;
      eng = (uc > 0 && ec > 0 && (rf <= re || rf - re <= 20)) ? 1 : 0;
      push_exp(ff, ef, us, es, uc, ec, eng);
   endtask

   task automatic clear_slots();
      for (int i = 0; i < NS; i++) begin
         u_typ[i] = '0;
         e_typ[i] = '0;
         u_loc[i] = LW'($urandom_range(0, 511));
         e_loc[i] = LW'($urandom_range(0, 511));
      end
   endtask

   task automatic set_mix();
      clear_slots();
      u_typ[3] = 2'd1; u_loc[3] = 9'd200;
      u_typ[7] = 2'd2; u_loc[7] = 9'd150;
      u_typ[9] = 2'd3; u_loc[9] = 9'd150;
      e_typ[2] = 2'd1; e_loc[2] = 9'd100;
      e_typ[5] = 2'd2; e_loc[5] = 9'd130;
   endtask

   task automatic start_pulse();
      @(negedge clk);
      Start = 1'b1;
      @(posedge clk);
      #1 Start = 1'b0;
   endtask

   task automatic compare_out(input string tag);
      exp_t e;
      check_val({tag, "_sb"}, 32'(sb_q.size() > 0), 1);
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         check_val({tag, "_ff"}, 32'(friendlyFront), 32'(e.ff));
         check_val({tag, "_ef"}, 32'(enemyFront), 32'(e.ef));
         check_val({tag, "_usel"}, 32'(unitDamageSelect), 32'(e.us));
         check_val({tag, "_esel"}, 32'(enemyDamageSelect), 32'(e.es));
         check_val({tag, "_ucnt"}, 32'(unitCount), 32'(e.uc));
         check_val({tag, "_ecnt"}, 32'(enemyCount), 32'(e.ec));
         check_val({tag, "_eng"}, 32'(engaged), 32'(e.eng));
      end
      $display("txn %s: ff=%0d ef=%0d usel=%0d esel=%0d ucnt=%0d ecnt=%0d eng=%0d",
               tag, friendlyFront, enemyFront, unitDamageSelect, enemyDamageSelect,
               unitCount, enemyCount, engaged);
   endtask

   // n0 = cycles already elapsed since the Start-sampling edge.
   task automatic wait_done(input string tag, input int n0);
      int n = n0;
      while (Done !== 1'b1 && n < 60) begin
         @(posedge clk);
         #1;
         n++;
      end
      check_val({tag, "_lat"}, 32'(n), NS + 2);
      compare_out(tag);
   endtask

   task automatic ack_done(input string tag);
      @(negedge clk);
      Ack = 1'b1;
      @(posedge clk);
      #1 Ack = 1'b0;
      check_val({tag, "_ack"}, 32'(Done), 0);
   endtask

   task automatic check_reset(input string tag);
      check_val({tag, "_ff"}, 32'(friendlyFront), 511);
      check_val({tag, "_ef"}, 32'(enemyFront), 0);
      check_val({tag, "_usel"}, 32'(unitDamageSelect), 16);
      check_val({tag, "_esel"}, 32'(enemyDamageSelect), 16);
      check_val({tag, "_ucnt"}, 32'(unitCount), 0);
      check_val({tag, "_ecnt"}, 32'(enemyCount), 0);
      check_val({tag, "_eng"}, 32'(engaged), 0);
      check_val({tag, "_done"}, 32'(Done), 0);
      $display("txn %s: reset state ff=%0d ef=%0d done=%0d", tag, friendlyFront, enemyFront, Done);
   endtask

   initial begin
      int hi;
      int n;
      clear_slots();
      #12;
      check_reset("rst");
      check_val("rst5_ff", 32'(ff5), 1023);
      @(negedge clk);
      rst = 1'b1;

      // All slots empty.
      clear_slots();
      push_exp(501, 10, 16, 16, 0, 0, 0);
      start_pulse();
      wait_done("empty", 0);
      ack_done("empty");

      // Mixed field with a tie at 150; Done must hold without Ack.
      set_mix();
      push_exp(140, 140, 7, 5, 3, 2, 1);
      start_pulse();
      wait_done("mix", 0);
      hi = 0;
      repeat (10) begin
         @(posedge clk);
         #1;
         if (Done === 1'b1) hi++;
      end
      check_val("hold_done", 32'(hi), 10);
      ack_done("mix");

      // Saturation at both ends.
      clear_slots();
      u_typ[0] = 2'd1; u_loc[0] = 9'd4;
      e_typ[15] = 2'd1; e_loc[15] = 9'd505;
      push_exp(0, 511, 0, 15, 1, 1, 1);
      start_pulse();
      wait_done("sat", 0);
      ack_done("sat");

      // Gap of 100 is not engaged.
      clear_slots();
      u_typ[0] = 2'd1; u_loc[0] = 9'd300;
      e_typ[15] = 2'd1; e_loc[15] = 9'd200;
      push_exp(290, 210, 0, 15, 1, 1, 0);
      start_pulse();
      wait_done("gap", 0);
      ack_done("gap");

      // Start during SCAN is ignored; Start+Ack in DONE returns to IDLE only.
      set_mix();
      push_exp(140, 140, 7, 5, 3, 2, 1);
      start_pulse();
      repeat (3) @(posedge clk);
      @(negedge clk);
      Start = 1'b1;
      @(posedge clk);
      #1 Start = 1'b0;
      wait_done("scanstart", 4);
      @(negedge clk);
      Start = 1'b1;
      Ack = 1'b1;
      @(posedge clk);
      #1;
      Start = 1'b0;
      Ack = 1'b0;
      check_val("startack_done", 32'(Done), 0);
      repeat (25) @(posedge clk);
      #1;
      check_val("startack_idle", 32'(Done), 0);
      check_val("startack_hold", 32'(unitCount), 3);

      // Reset in the middle of a scan aborts it.
      set_mix();
      start_pulse();
      repeat (6) @(posedge clk);
      #3 rst = 1'b0;
      #1 check_reset("abort");
      @(negedge clk);
      rst = 1'b1;
      push_exp(140, 140, 7, 5, 3, 2, 1);
      start_pulse();
      wait_done("after_abort", 0);
      ack_done("after_abort");

      // Random fields against the reference model.
      for (int t = 0; t < 6; t++) begin
         clear_slots();
         for (int i = 0; i < NS; i++) begin
            u_typ[i] = TW'($urandom_range(0, 3));
            e_typ[i] = TW'($urandom_range(0, 3));
         end
         if (t[0]) begin
            u_loc[11] = u_loc[4];
            e_loc[12] = e_loc[6];
         end
         model_push();
         start_pulse();
         wait_done($sformatf("rand%0d", t), 0);
         ack_done($sformatf("rand%0d", t));
      end

      // Five-slot instance.
      @(negedge clk);
      start5 = 1'b1;
      @(posedge clk);
      #1 start5 = 1'b0;
      n = 0;
      while (done5 !== 1'b1 && n < 60) begin
         @(posedge clk);
         #1;
         n++;
      end
      check_val("n5_lat", 32'(n), 7);
      check_val("n5_usel", 32'(us5), 8);
      check_val("n5_esel", 32'(es5), 8);
      check_val("n5_ff", 32'(ff5), 1013);
      check_val("n5_ef", 32'(ef5), 10);
      check_val("n5_ucnt", 32'(uc5), 0);
      check_val("n5_eng", 32'(eng5), 0);
      $display("txn n5: ff=%0d ef=%0d usel=%0d esel=%0d", ff5, ef5, us5, es5);
      @(negedge clk);
      ack5 = 1'b1;
      @(posedge clk);
      #1 ack5 = 1'b0;
      check_val("n5_ack", 32'(done5), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
